// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// Receives a program image over an 8N1 UART line and writes it word by word
// into instruction memory while holding the CPU.
//   byte 0       : word count N (0 means 256 words)
//   bytes 1..4N  : instruction words, little-endian
//   last byte    : 8-bit additive checksum of the data bytes, only when
//                  built with `define LOADER_CHECKSUM_EN
// Without LOADER_CHECKSUM_EN the checksum state and accumulator are not built
// and chk_err is tied low.
module uart_prog_loader #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock_reg,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [31:0]           wd,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  frame_err,
    output logic                  chk_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int TIMER_W      = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TIMER_W-1:0]    HALF_BIT  = TIMER_W'(CLKS_PER_BIT / 2);
    localparam logic [TIMER_W-1:0]    FULL_BIT  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_COUNT,
        L_DATA,
        L_CHK,
        L_DONE
    } ld_state_t;

    // ------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------
    logic                rx_meta;
    logic                rx_sync;

    rx_state_t           rx_state;
    rx_state_t           rx_state_next;
    logic [TIMER_W-1:0]  bit_timer;
    logic [TIMER_W-1:0]  bit_timer_next;
    logic [2:0]          bit_cnt;
    logic [2:0]          bit_cnt_next;
    logic [7:0]          shift_reg;
    logic [7:0]          shift_reg_next;
    logic                byte_valid;
    logic                byte_valid_next;
    logic [7:0]          rx_byte;
    logic [7:0]          rx_byte_next;
    logic                frame_err_next;

    // ------------------------------------------------------------------
    // Loader signals
    // ------------------------------------------------------------------
    ld_state_t           ld_state;
    ld_state_t           ld_state_next;
    logic [8:0]          words_left;
    logic [8:0]          words_left_next;
    logic [1:0]          byte_idx;
    logic [1:0]          byte_idx_next;
    logic                we_next;
    logic [ADDR_WIDTH-1:0] wa_next;
    logic [31:0]         wd_next;
    logic                cpu_hold_next;
    logic                done_next;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_acc;
    logic [7:0]          chk_acc_next;
    logic                chk_err_next;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            rx_state   <= R_IDLE;
            bit_timer  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_next;
            bit_timer  <= bit_timer_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_reg_next;
            byte_valid <= byte_valid_next;
            rx_byte    <= rx_byte_next;
            frame_err  <= frame_err_next;
        end
    end

    // Receiver next state: start bit checked at mid-bit, then one sample per bit period
    always_comb begin
        rx_state_next   = rx_state;
        bit_timer_next  = bit_timer;
        bit_cnt_next    = bit_cnt;
        shift_reg_next  = shift_reg;
        byte_valid_next = 1'b0;
        rx_byte_next    = rx_byte;
        frame_err_next  = frame_err;

        case (rx_state)
            R_IDLE: begin
                if (!rx_sync) begin
                    rx_state_next  = R_START;
                    bit_timer_next = '0;
                end
            end

            R_START: begin
                if (bit_timer == HALF_BIT) begin
                    bit_timer_next = '0;
                    if (rx_sync) begin
                        rx_state_next = R_IDLE;
                    end else begin
                        rx_state_next = R_DATA;
                        bit_cnt_next  = '0;
                    end
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end

            R_DATA: begin
                if (bit_timer == FULL_BIT) begin
                    bit_timer_next = '0;
                    shift_reg_next = {rx_sync, shift_reg[7:1]};
                    bit_cnt_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        rx_state_next = R_STOP;
                    end
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end

            R_STOP: begin
                if (bit_timer == FULL_BIT) begin
                    bit_timer_next = '0;
                    rx_state_next  = R_IDLE;
                    if (rx_sync) begin
                        byte_valid_next = 1'b1;
                        rx_byte_next    = shift_reg;
                    end else begin
                        frame_err_next  = 1'b1;
                    end
                end else begin
                    bit_timer_next = bit_timer + 1'b1;
                end
            end

            default: begin
                rx_state_next = R_IDLE;
            end
        endcase
    end

    // Loader state and output registers; every memory-side output is registered
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            ld_state   <= L_IDLE;
            words_left <= '0;
            byte_idx   <= '0;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= '0;
            chk_err    <= 1'b0;
`endif
        end else begin
            ld_state   <= ld_state_next;
            words_left <= words_left_next;
            byte_idx   <= byte_idx_next;
            we         <= we_next;
            wa         <= wa_next;
            wd         <= wd_next;
            cpu_hold   <= cpu_hold_next;
            done       <= done_next;
`ifdef LOADER_CHECKSUM_EN
            chk_acc    <= chk_acc_next;
            chk_err    <= chk_err_next;
`endif
        end
    end

`ifndef LOADER_CHECKSUM_EN
    assign chk_err = 1'b0;
`endif

    // Loader next state: count byte, little-endian word assembly, write pulse, completion
    always_comb begin
        ld_state_next   = ld_state;
        words_left_next = words_left;
        byte_idx_next   = byte_idx;
        we_next         = 1'b0;
        wa_next         = wa;
        wd_next         = wd;
        cpu_hold_next   = cpu_hold;
        done_next       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_acc_next    = chk_acc;
        chk_err_next    = chk_err;
`endif

        case (ld_state)
            L_IDLE, L_COUNT: begin
                if (byte_valid) begin
                    words_left_next = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    byte_idx_next   = '0;
                    wa_next         = '0;
                    cpu_hold_next   = 1'b1;
                    ld_state_next   = L_DATA;
`ifdef LOADER_CHECKSUM_EN
                    chk_acc_next    = '0;
`endif
                end
            end

            L_DATA: begin
                if (byte_valid) begin
                    case (byte_idx)
                        2'd0:    wd_next[7:0]   = rx_byte;
                        2'd1:    wd_next[15:8]  = rx_byte;
                        2'd2:    wd_next[23:16] = rx_byte;
                        default: wd_next[31:24] = rx_byte;
                    endcase
                    byte_idx_next = byte_idx + 1'b1;
                    if (byte_idx == 2'd3) begin
                        we_next = 1'b1;
                    end
`ifdef LOADER_CHECKSUM_EN
                    chk_acc_next = chk_acc + rx_byte;
`endif
                end
                if (we) begin
                    wa_next         = wa + WORD_STEP;
                    words_left_next = words_left - 9'd1;
                    if (words_left == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        ld_state_next = L_CHK;
`else
                        ld_state_next = L_DONE;
                        done_next     = 1'b1;
                        cpu_hold_next = 1'b0;
`endif
                    end
                end
            end

            L_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (byte_valid) begin
                    if (rx_byte != chk_acc) begin
                        chk_err_next = 1'b1;
                    end
                    done_next     = 1'b1;
                    cpu_hold_next = 1'b0;
                    ld_state_next = L_DONE;
                end
`else
                ld_state_next = L_IDLE;
`endif
            end

            L_DONE: begin
                wa_next         = '0;
                words_left_next = '0;
                byte_idx_next   = '0;
                ld_state_next   = L_IDLE;
            end

            default: begin
                ld_state_next = L_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader. Expected writes are queued as
// stimulus is issued; a monitor pops and compares on every write pulse.
// Bit period is shortened to 4 clocks so the 256-word wrap image stays short.
module tb_uart_prog_loader;

    localparam int CLK_FREQ   = 400000;
    localparam int BAUD       = 100000;
    localparam int ADDR_WIDTH = 8;
    localparam int CPB        = CLK_FREQ / BAUD;

    logic                  clock_reg;
    logic                  reset;
    logic                  rx;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [31:0]           wd;
    logic                  cpu_hold;
    logic                  done;
    logic                  frame_err;
    logic                  chk_err;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         done_seen = 0;

    uart_prog_loader #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clock_reg(clock_reg),
        .reset    (reset),
        .rx       (rx),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .cpu_hold (cpu_hold),
        .done     (done),
        .frame_err(frame_err),
        .chk_err  (chk_err)
    );

    initial clock_reg = 1'b0;
    always #5 clock_reg = ~clock_reg;

    function automatic wr_t mkWr(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_reg);
    endtask

    // One 8N1 frame followed by one idle bit; stop_bit=0 forces a framing error
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock_reg);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock_reg);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clock_reg);
        rx = 1'b1;
        repeat (CPB) @(negedge clock_reg);
    endtask

    task automatic sendQueue();
        while (tx_q.size() != 0) begin
            applyStimulus(tx_q.pop_front(), 1'b1);
        end
    endtask

    task automatic applyReset();
        @(negedge clock_reg);
        reset = 1'b0;
        @(negedge clock_reg);
        reset = 1'b1;
    endtask

    // Monitor: every write pulse must match the head of the expected queue
    always @(negedge clock_reg) begin : monitor
        wr_t e;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got wa=0x%0h wd=0x%0h, expected no write", wa, wd);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(wa), 32'(e.addr));
                checkOutput("write_data", wd, e.data);
                checkOutput("hold_during_write", 32'(cpu_hold), 32'd1);
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            checkOutput("hold_at_done", 32'(cpu_hold), 32'd0);
        end
    end

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int         base;
        logic [7:0] sum;
        logic [7:0] b0, b1, b2, b3;

        rx    = 1'b1;
        reset = 1'b0;
        idle(5);

        // Reset state
        checkOutput("reset_we", 32'(we), 32'd0);
        checkOutput("reset_wa", 32'(wa), 32'd0);
        checkOutput("reset_wd", wd, 32'd0);
        checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_chk_err", 32'(chk_err), 32'd0);
        reset = 1'b1;
        idle(10);

        // Basic load: two words
        $display("[TB] basic load");
        base = done_seen;
        exp_q.push_back(mkWr(8'h00, 32'h00000513));
        exp_q.push_back(mkWr(8'h04, 32'h00A505B3));
        applyStimulus(8'h02, 1'b1);
        idle(4);
        checkOutput("hold_after_count", 32'(cpu_hold), 32'd1);
        tx_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
        sendQueue();
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'h75, 1'b1);
`endif
        idle(20);
        checkOutput("basic_done_count", 32'(done_seen - base), 32'd1);
        checkOutput("basic_hold_released", 32'(cpu_hold), 32'd0);
        checkOutput("basic_wa_rewound", 32'(wa), 32'd0);
        checkOutput("basic_frame_err", 32'(frame_err), 32'd0);
        checkOutput("basic_chk_err", 32'(chk_err), 32'd0);
        checkOutput("basic_pending", 32'(exp_q.size()), 32'd0);

        // Framing error: the bad 0x55 frame is dropped, 11 22 33 44 form the word,
        // and the trailing 0x55 opens a new image as its count byte
        $display("[TB] framing error");
        applyReset();
        base = done_seen;
        exp_q.push_back(mkWr(8'h00, 32'h44332211));
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h55, 1'b0);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        sendQueue();
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'hAA, 1'b1);
`endif
        applyStimulus(8'h55, 1'b1);
        idle(20);
        checkOutput("frame_err_sticky", 32'(frame_err), 32'd1);
        checkOutput("frame_done_count", 32'(done_seen - base), 32'd1);
        checkOutput("frame_pending", 32'(exp_q.size()), 32'd0);
        checkOutput("frame_new_image_hold", 32'(cpu_hold), 32'd1);

        // False start: a glitch shorter than half a bit is ignored silently
        $display("[TB] false start");
        applyReset();
        base = done_seen;
        rx = 1'b0;
        @(negedge clock_reg);
        rx = 1'b1;
        idle(3 * CPB);
        checkOutput("glitch_no_hold", 32'(cpu_hold), 32'd0);
        exp_q.push_back(mkWr(8'h00, 32'hDDCCBBAA));
        tx_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        sendQueue();
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'h0E, 1'b1);
`endif
        idle(20);
        checkOutput("glitch_frame_err", 32'(frame_err), 32'd0);
        checkOutput("glitch_done_count", 32'(done_seen - base), 32'd1);
        checkOutput("glitch_pending", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a three-word image
        $display("[TB] reset mid-image");
        applyReset();
        exp_q.push_back(mkWr(8'h00, 32'hA3A2A1A0));
        tx_q = '{8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        sendQueue();
        idle(8);
        checkOutput("midimg_pending", 32'(exp_q.size()), 32'd0);
        checkOutput("midimg_wa_advanced", 32'(wa), 32'd4);
        applyReset();
        idle(2);
        checkOutput("midimg_hold_dropped", 32'(cpu_hold), 32'd0);
        checkOutput("midimg_wa_cleared", 32'(wa), 32'd0);
        base = done_seen;
        exp_q.push_back(mkWr(8'h00, 32'h04030201));
        tx_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        sendQueue();
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'h0A, 1'b1);
`endif
        idle(20);
        checkOutput("midimg_done_count", 32'(done_seen - base), 32'd1);
        checkOutput("midimg_pending_after", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum: correct then incorrect trailer
        $display("[TB] checksum");
        applyReset();
        base = done_seen;
        exp_q.push_back(mkWr(8'h00, 32'h04030201));
        tx_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        sendQueue();
        idle(4);
        checkOutput("chk_hold_waiting", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h0A, 1'b1);
        idle(20);
        checkOutput("chk_good", 32'(chk_err), 32'd0);
        exp_q.push_back(mkWr(8'h00, 32'h04030201));
        tx_q = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        sendQueue();
        idle(20);
        checkOutput("chk_bad", 32'(chk_err), 32'd1);
        checkOutput("chk_done_count", 32'(done_seen - base), 32'd2);
        checkOutput("chk_pending", 32'(exp_q.size()), 32'd0);
`endif

        // Wrap: count 0 means 256 words; addresses wrap after 0xFC
        $display("[TB] wrap");
        applyReset();
        base = done_seen;
        sum  = 8'h00;
        applyStimulus(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            b0 = 8'h5A;
            b1 = 8'(i);
            b2 = ~8'(i);
            b3 = 8'(i) ^ 8'h3C;
            exp_q.push_back(mkWr(8'(i * 4), {b3, b2, b1, b0}));
            sum = sum + b0 + b1 + b2 + b3;
            applyStimulus(b0, 1'b1);
            applyStimulus(b1, 1'b1);
            applyStimulus(b2, 1'b1);
            applyStimulus(b3, 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(sum, 1'b1);
`endif
        idle(20);
        checkOutput("wrap_done_count", 32'(done_seen - base), 32'd1);
        checkOutput("wrap_wa_zero", 32'(wa), 32'd0);
        checkOutput("wrap_hold_released", 32'(cpu_hold), 32'd0);
        checkOutput("wrap_pending", 32'(exp_q.size()), 32'd0);
        idle(40);
        checkOutput("wrap_done_stable", 32'(done_seen - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
